// File: rtl/slave_serial_rx.sv
// slave_serial_rx: serial slave receive port for the system bus.
// After a valid/ready handshake it shifts in a bit-serial address, and for
// writes a burst of 1..2^BURST_W data beats. All strobes are one-cycle pulses
// and all outputs are registered, except slave_ready, which is decoded from state.
module slave_serial_rx #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_W    = 2,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_address,
  input  logic                  rx_data,
  input  logic                  master_valid,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [BURST_W-1:0]    burst_len,
  output logic                  slave_ready,
  output logic                  is_write,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  addr_valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic [BURST_W-1:0]    beat_idx,
  output logic                  rx_done,
  output logic                  err
);

  // One bit counter serves both the address phase and the data phase.
  localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [BURST_W-1:0]    beat_q, beat_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BURST_W-1:0]    beat_idx_q, beat_idx_d;
  logic                  is_write_q, is_write_d;
  logic                  addr_valid_q, addr_valid_d;
  logic                  data_valid_q, data_valid_d;
  logic                  rx_done_q, rx_done_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] data_next;

  // Shift one serial bit into the address register. In MSB-first order the
  // word grows from the top; in LSB-first order new bits enter at the MSB and
  // move down, so that bit 0 ends up in position 0.
  function automatic logic [ADDR_WIDTH-1:0] shift_addr(input logic [ADDR_WIDTH-1:0] sh,
                                                       input logic b);
    if (MSB_FIRST != 0) shift_addr = (sh << 1) | ADDR_WIDTH'(b);
    else                shift_addr = (sh >> 1) | (ADDR_WIDTH'(b) << (ADDR_WIDTH - 1));
  endfunction

  // Same as shift_addr, for the data beat register.
  function automatic logic [DATA_WIDTH-1:0] shift_data(input logic [DATA_WIDTH-1:0] sh,
                                                       input logic b);
    if (MSB_FIRST != 0) shift_data = (sh << 1) | DATA_WIDTH'(b);
    else                shift_data = (sh >> 1) | (DATA_WIDTH'(b) << (DATA_WIDTH - 1));
  endfunction

  assign addr_next = shift_addr(addr_sh_q, rx_address);
  assign data_next = shift_data(data_sh_q, rx_data);

  // Next-state logic: handshake, bit and beat sequencing, abort and error detection.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    beat_d       = beat_q;
    burst_d      = burst_q;
    addr_sh_d    = addr_sh_q;
    data_sh_d    = data_sh_q;
    address_d    = address_q;
    data_d       = data_q;
    beat_idx_d   = beat_idx_q;
    is_write_d   = is_write_q;
    addr_valid_d = 1'b0;
    data_valid_d = 1'b0;
    rx_done_d    = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (master_valid) begin
          if (read_en ^ write_en) begin
            state_d    = S_ADDR;
            is_write_d = write_en;
            burst_d    = burst_len;
            bit_cnt_d  = '0;
            beat_d     = '0;
          end else if (read_en && write_en) begin
            err_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (!master_valid) begin
          // An abort drops the partial word; address keeps its last complete value.
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          addr_sh_d = addr_next;
          if (bit_cnt_q == ADDR_LAST) begin
            address_d    = addr_next;
            addr_valid_d = 1'b1;
            bit_cnt_d    = '0;
            if (is_write_q) begin
              state_d = S_DATA;
            end else begin
              state_d   = S_IDLE;
              rx_done_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (!master_valid) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          data_sh_d = data_next;
          if (bit_cnt_q == DATA_LAST) begin
            data_d       = data_next;
            beat_idx_d   = beat_q;
            data_valid_d = 1'b1;
            bit_cnt_d    = '0;
            // The beat index is compared before it is incremented, so a burst
            // of 2^BURST_W beats ends before the counter can wrap.
            if (beat_q == burst_q) begin
              state_d   = S_IDLE;
              rx_done_d = 1'b1;
            end else begin
              beat_d = beat_q + BURST_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      beat_q       <= '0;
      burst_q      <= '0;
      addr_sh_q    <= '0;
      data_sh_q    <= '0;
      address_q    <= '0;
      data_q       <= '0;
      beat_idx_q   <= '0;
      is_write_q   <= 1'b0;
      addr_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      rx_done_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      beat_q       <= beat_d;
      burst_q      <= burst_d;
      addr_sh_q    <= addr_sh_d;
      data_sh_q    <= data_sh_d;
      address_q    <= address_d;
      data_q       <= data_d;
      beat_idx_q   <= beat_idx_d;
      is_write_q   <= is_write_d;
      addr_valid_q <= addr_valid_d;
      data_valid_q <= data_valid_d;
      rx_done_q    <= rx_done_d;
      err_q        <= err_d;
    end
  end

  // slave_ready is decoded from state so that a new handshake can be taken
  // in the rx_done cycle itself.
  assign slave_ready = (state_q == S_IDLE);
  assign is_write    = is_write_q;
  assign address     = address_q;
  assign addr_valid  = addr_valid_q;
  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign beat_idx    = beat_idx_q;
  assign rx_done     = rx_done_q;
  assign err         = err_q;

endmodule
